// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART access sequencer.
package uart_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StWrWaitTbre,
    StWrWaitTsre,
    StRdPulse,
    StRdHold,
    StDone
  } uart_state_e;

  localparam int unsigned DefPulseCycles = 2;
  localparam int unsigned DefTimeout     = 1023;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, synchronous active-high reset.
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_ctrl.sv
// Sequences single-byte UART reads/writes on the shared UART/RAM1 bus for the mem stage.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES = DefPulseCycles,
  parameter int unsigned TIMEOUT      = DefTimeout
) (
  input  logic        uci_clk,
  input  logic        uci_rst,
  input  logic        uci_req_valid,
  input  logic        uci_req_write,
  input  logic [7:0]  uci_wdata,
  output logic        uco_req_ready,
  output logic        uco_done,
  output logic [7:0]  uco_rdata,
  output logic        uco_timeout,
  output logic        uco_writeable,
  output logic        uco_data_ready,
  output logic        uco_ram1_disable,
  output logic        uco_bus_oe,
  output logic [15:0] uco_bus_data,
  input  logic [15:0] uci_bus_data,
  output logic        uco_wrn,
  output logic        uco_rdn,
  input  logic        uci_uart_tbre,
  input  logic        uci_uart_tsre,
  input  logic        uci_uart_data_ready
);

  localparam logic [3:0] PulseLast = 4'(PULSE_CYCLES);
  localparam logic [9:0] WaitLast  = 10'(TIMEOUT - 1);

  uart_state_e state_q, state_d;
  logic [3:0]  pulse_cnt_q, pulse_cnt_d;
  logic [9:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        timeout_d;
  logic        wrn_q, rdn_q, bus_oe_q, ram1_q, done_q, timeout_q;
  logic        tbre_s, tsre_s, data_ready_s;
  logic        unused_bus_hi;

  sync2 u_sync_tbre (
    .clk_i (uci_clk),
    .rst_i (uci_rst),
    .d_i   (uci_uart_tbre),
    .q_o   (tbre_s)
  );

  sync2 u_sync_tsre (
    .clk_i (uci_clk),
    .rst_i (uci_rst),
    .d_i   (uci_uart_tsre),
    .q_o   (tsre_s)
  );

  sync2 u_sync_dr (
    .clk_i (uci_clk),
    .rst_i (uci_rst),
    .d_i   (uci_uart_data_ready),
    .q_o   (data_ready_s)
  );

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    timeout_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (uci_req_valid) begin
          // Both pulse states start counting from 1; WR_SETUP leaves the count untouched.
          pulse_cnt_d = 4'd1;
          if (uci_req_write) begin
            wdata_d = uci_wdata;
            state_d = StWrSetup;
          end else begin
            state_d = StRdPulse;
          end
        end
      end
      StWrSetup: state_d = StWrPulse;
      StWrPulse: begin
        if (pulse_cnt_q >= PulseLast) state_d = StWrHold;
        else                          pulse_cnt_d = pulse_cnt_q + 4'd1;
      end
      StWrHold: begin
        wait_cnt_d = '0;
        state_d    = StWrWaitTbre;
      end
      StWrWaitTbre, StWrWaitTsre: begin
        if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 10'd1;
        if (state_q == StWrWaitTbre && tbre_s) begin
          state_d = StWrWaitTsre;
        end else if (state_q == StWrWaitTsre && tsre_s) begin
          state_d = StDone;
        end else if (wait_cnt_q >= WaitLast) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
      end
      StRdPulse: begin
        if (pulse_cnt_q >= PulseLast) begin
          rdata_d = uci_bus_data[7:0];
          state_d = StRdHold;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 4'd1;
        end
      end
      StRdHold: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Strobes and bus enables are decoded from the next state so they are glitch-free flops.
  always_ff @(posedge uci_clk) begin
    if (uci_rst) begin
      state_q     <= StIdle;
      pulse_cnt_q <= '0;
      wait_cnt_q  <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      wrn_q       <= 1'b1;
      rdn_q       <= 1'b1;
      bus_oe_q    <= 1'b0;
      ram1_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      wrn_q       <= (state_d != StWrPulse);
      rdn_q       <= (state_d != StRdPulse);
      bus_oe_q    <= (state_d inside {StWrSetup, StWrPulse, StWrHold});
      ram1_q      <= (state_d != StIdle);
      done_q      <= (state_d == StDone);
      timeout_q   <= timeout_d;
    end
  end

  assign unused_bus_hi    = ^uci_bus_data[15:8];
  assign uco_req_ready    = (state_q == StIdle);
  assign uco_done         = done_q;
  assign uco_rdata        = rdata_q;
  assign uco_timeout      = timeout_q;
  assign uco_writeable    = tbre_s & tsre_s & (state_q == StIdle);
  assign uco_data_ready   = data_ready_s & (state_q == StIdle);
  assign uco_ram1_disable = ram1_q;
  assign uco_bus_oe       = bus_oe_q;
  assign uco_bus_data     = {8'h00, wdata_q};
  assign uco_wrn          = wrn_q;
  assign uco_rdn          = rdn_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl: transaction-level model checked every cycle plus directed literal checks.
module tb_uart_ctrl;

  localparam int P  = 2;
  localparam int TO = 1023;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_write;
  logic [7:0]  wdata;
  logic [15:0] bus_in;
  logic        tbre_in, tsre_in, dr_in;
  logic        uco_req_ready, uco_done, uco_timeout, uco_writeable, uco_data_ready;
  logic        uco_ram1_disable, uco_bus_oe, uco_wrn, uco_rdn;
  logic [7:0]  uco_rdata;
  logic [15:0] uco_bus_data;

  always #5 clk = ~clk;

  uart_ctrl #(
    .PULSE_CYCLES (P),
    .TIMEOUT      (TO)
  ) dut (
    .uci_clk             (clk),
    .uci_rst             (rst),
    .uci_req_valid       (req_valid),
    .uci_req_write       (req_write),
    .uci_wdata           (wdata),
    .uco_req_ready       (uco_req_ready),
    .uco_done            (uco_done),
    .uco_rdata           (uco_rdata),
    .uco_timeout         (uco_timeout),
    .uco_writeable       (uco_writeable),
    .uco_data_ready      (uco_data_ready),
    .uco_ram1_disable    (uco_ram1_disable),
    .uco_bus_oe          (uco_bus_oe),
    .uco_bus_data        (uco_bus_data),
    .uci_bus_data        (bus_in),
    .uco_wrn             (uco_wrn),
    .uco_rdn             (uco_rdn),
    .uci_uart_tbre       (tbre_in),
    .uci_uart_tsre       (tsre_in),
    .uci_uart_data_ready (dr_in)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: t counts cycles since the accepting edge (t=1 is the first busy cycle).
  bit          m_active = 0, m_wr = 0, m_done = 0, m_to = 0, m_gt = 0;
  int          m_t = 0, m_nw = 0;
  logic [15:0] m_bus = '0;
  logic [7:0]  m_rdata = '0;
  bit          s1_tb = 0, s2_tb = 0, s1_ts = 0, s2_ts = 0, s1_dr = 0, s2_dr = 0;

  always @(posedge clk) begin : model
    bit a, w, d, to, gt;
    int tt, nw;
    logic [15:0] bus;
    logic [7:0]  rd;
    a = m_active; w = m_wr; d = m_done; to = m_to; gt = m_gt;
    tt = m_t; nw = m_nw; bus = m_bus; rd = m_rdata;
    if (rst) begin
      a = 0; d = 0; to = 0; bus = '0; rd = '0;
    end else if (d) begin
      d = 0; to = 0;
    end else if (!a) begin
      if (req_valid) begin
        a = 1; w = req_write; tt = 1; nw = 0; gt = 0;
        if (req_write) bus = {8'h00, wdata};
      end
    end else begin
      tt++;
      if (!w) begin
        if (tt == P + 1) rd = bus_in[7:0];
        if (tt == P + 2) begin a = 0; d = 1; end
      end else if (tt >= P + 4) begin
        nw++;
        if (!gt && s2_tb)      gt = 1;
        else if (gt && s2_ts)  begin a = 0; d = 1; end
        else if (nw >= TO)     begin a = 0; d = 1; to = 1; end
      end
    end
    m_active <= a; m_wr <= w; m_done <= d; m_to <= to; m_gt <= gt;
    m_t <= tt; m_nw <= nw; m_bus <= bus; m_rdata <= rd;
    s2_tb <= rst ? 1'b0 : s1_tb;  s1_tb <= rst ? 1'b0 : tbre_in;
    s2_ts <= rst ? 1'b0 : s1_ts;  s1_ts <= rst ? 1'b0 : tsre_in;
    s2_dr <= rst ? 1'b0 : s1_dr;  s1_dr <= rst ? 1'b0 : dr_in;
  end

  always @(negedge clk) begin : compare
    bit idle;
    if (chk_en) begin
      idle = !m_active && !m_done;
      chk("req_ready", uco_req_ready, idle);
      chk("done", uco_done, m_done);
      chk("timeout", uco_timeout, m_to);
      chk("ram1_disable", uco_ram1_disable, !idle);
      chk("bus_oe", uco_bus_oe, m_active && m_wr && m_t <= P + 2);
      chk("wrn", uco_wrn, !(m_active && m_wr && m_t >= 2 && m_t <= P + 1));
      chk("rdn", uco_rdn, !(m_active && !m_wr && m_t <= P));
      chk("bus_data", uco_bus_data, m_bus);
      chk("rdata", uco_rdata, m_rdata);
      chk("writeable", uco_writeable, idle && s2_tb && s2_ts);
      chk("data_ready", uco_data_ready, idle && s2_dr);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // mode 1: transmitter busy for 20 cycles after the strobe; mode 2: read bus pattern.
  task automatic run_txn(input bit wr, input logic [7:0] wd, input int mode, input int bound,
                         output int done_k, output int strobe_low, output int first_oe,
                         output bit to_seen, output bit busy_ok);
    done_k = 0; strobe_low = 0; first_oe = 0; to_seen = 0; busy_ok = 1;
    next_cycle();
    req_valid = 1; req_write = wr; wdata = wd;
    for (int k = 1; k <= bound && done_k == 0; k++) begin
      next_cycle();
      if (mode == 1 && k == 3)  begin tbre_in = 0; tsre_in = 0; end
      if (mode == 1 && k == 23) begin tbre_in = 1; tsre_in = 1; end
      if (mode == 2) bus_in = (k <= P) ? 16'hA55A : 16'h00C3;
      @(negedge clk);
      if (uco_bus_oe && first_oe == 0) begin
        first_oe = k;
        chk("setup_bus_data", uco_bus_data, {8'h00, wd});
        chk("setup_wrn_high", uco_wrn, 1'b1);
      end
      if (wr ? !uco_wrn : !uco_rdn) strobe_low++;
      if (!uco_ram1_disable || uco_data_ready || uco_writeable || uco_req_ready) busy_ok = 0;
      if (uco_done) begin
        done_k  = k;
        to_seen = uco_timeout;
      end
    end
    next_cycle();
    req_valid = 0;
  endtask

  int dk, sl, fo, d1, d2;
  bit ts, bo, seen;

  initial begin
    rst = 1; req_valid = 0; req_write = 0; wdata = '0;
    bus_in = 16'h00C3; tbre_in = 0; tsre_in = 0; dr_in = 0;
    next_cycle();
    chk_en = 1;
    next_cycle();
    @(negedge clk);
    chk("rst_wrn", uco_wrn, 1'b1);
    chk("rst_rdn", uco_rdn, 1'b1);
    chk("rst_bus_oe", uco_bus_oe, 1'b0);
    chk("rst_ram1", uco_ram1_disable, 1'b0);
    chk("rst_ready", uco_req_ready, 1'b1);
    rst = 0;
    tbre_in = 1; tsre_in = 1;
    repeat (4) next_cycle();

    // Fast write of 8'h41
    run_txn(1'b1, 8'h41, 0, 40, dk, sl, fo, ts, bo);
    chk("wr_first_oe_cycle", fo, 1);
    chk("wr_strobe_len", sl, 2);
    chk("wr_done_cycle", dk, 7);
    chk("wr_no_timeout", ts, 1'b0);
    chk("wr_busy_flags", bo, 1'b1);
    repeat (3) next_cycle();

    // Transmitter busy for 20 cycles
    run_txn(1'b1, 8'hC7, 1, 80, dk, sl, fo, ts, bo);
    chk("slow_wr_done_cycle", dk, 27);
    chk("slow_wr_no_timeout", ts, 1'b0);
    repeat (3) next_cycle();

    // Read with data ready
    dr_in = 1;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("idle_data_ready", uco_data_ready, 1'b1);
    run_txn(1'b0, 8'h00, 2, 40, dk, sl, fo, ts, bo);
    chk("rd_strobe_len", sl, 2);
    chk("rd_done_cycle", dk, 4);
    chk("rd_data", uco_rdata, 8'h5A);
    chk("rd_no_oe", fo, 0);
    chk("rd_busy_flags", bo, 1'b1);
    dr_in = 0;
    repeat (3) next_cycle();

    // Transmitter never ready: timeout
    tbre_in = 0;
    repeat (4) next_cycle();
    run_txn(1'b1, 8'h55, 0, 1100, dk, sl, fo, ts, bo);
    chk("to_done_cycle", dk, 4 + TO + 1);
    chk("to_flag", ts, 1'b1);
    chk("to_strobe_len", sl, 2);
    @(negedge clk);
    chk("to_back_idle", uco_req_ready, 1'b1);
    chk("to_wrn_idle", uco_wrn, 1'b1);
    tbre_in = 1;
    repeat (4) next_cycle();

    // Reset during the write pulse
    req_valid = 1; req_write = 1; wdata = 8'h99;
    next_cycle();
    next_cycle();
    rst = 1; req_valid = 0;
    @(negedge clk);
    chk("prerst_wrn_low", uco_wrn, 1'b0);
    next_cycle();
    rst = 0;
    @(negedge clk);
    chk("midrst_wrn", uco_wrn, 1'b1);
    chk("midrst_oe", uco_bus_oe, 1'b0);
    chk("midrst_ready", uco_req_ready, 1'b1);
    chk("midrst_ram1", uco_ram1_disable, 1'b0);
    seen = 0;
    repeat (10) begin
      next_cycle();
      @(negedge clk);
      if (uco_done) seen = 1;
    end
    chk("midrst_no_done", seen, 1'b0);

    // req_valid held through done: second access follows
    next_cycle();
    req_valid = 1; req_write = 1; wdata = 8'h7E;
    d1 = 0; d2 = 0;
    for (int k = 1; k <= 40 && d2 == 0; k++) begin
      next_cycle();
      @(negedge clk);
      if (uco_done) begin
        if (d1 == 0) d1 = k;
        else         d2 = k;
      end
      if (k == 8) chk("b2b_idle_ready", uco_req_ready, 1'b1);
      if (k == 9) chk("b2b_ready_drop", uco_req_ready, 1'b0);
    end
    next_cycle();
    req_valid = 0;
    chk("b2b_first_done", d1, 7);
    chk("b2b_second_done", d2, 15);
    repeat (4) next_cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
